uart_rx: RTL and testbench

Asynchronous serial receiver for the FPGA UART path: 8 data bits, no parity, 1 stop bit (8N1), LSB first. It is the consuming stage for the `tx` line driven by `top`, used both as a loopback checker on the board and as the command input for the design. It synchronises the raw line, validates the start bit, samples each bit at its centre and emits one byte per frame with a single-cycle strobe. Framing errors are flagged without stalling the receiver.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and line-rate constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  localparam int CLK_HZ               = 12_000_000;
  localparam int BAUD                 = 9600;
  localparam int CLKS_PER_BIT_DEFAULT = CLK_HZ / BAUD;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a configurable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises rx, validates the start bit, samples bit centres and
// emits one byte per frame. rx_state exposes the FSM state for debug.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 hwclk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy,
  output uart_state_e          rx_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int H     = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (hwclk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Strobes are one-cycle pulses with no back-pressure; the consumer must take
  // rx_data in the cycle rx_valid (or rx_frame_err) is high or rely on it holding.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        // Leaving at the stop-bit centre leaves half a bit to catch a back-to-back start edge.
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          data_d = shift_q;
          if (rx_s) begin
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = err_q;
  assign rx_busy      = (state_q != IDLE);
  assign rx_state     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: serialiser tasks push expected frames, a negedge
// monitor records strobes, and each test pops and compares them.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB       = 16;
  localparam int H         = CPB / 2;
  localparam int FRAME_LAT = 3 + H + 9 * CPB;
  localparam int W         = 41;  // {strobe edge[31:0], frame_err, data[7:0]}

  logic        hwclk = 1'b0;
  logic        rst   = 1'b1;
  logic        rx    = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_frame_err, rx_busy;
  uart_state_e rx_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  logic [41:0]  obs_mem [256];  // {edge[31:0], valid, frame_err, data[7:0]}
  int obs_wr = 0;
  int obs_rd = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .hwclk        (hwclk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy),
    .rx_state     (rx_state)
  );

  // clock / cycle counter
  always #5 hwclk = ~hwclk;
  always @(posedge hwclk) cyc <= cyc + 1;

  // monitor: record every strobe with the number of the edge that samples it
  always @(negedge hwclk) begin
    if (rx_valid || rx_frame_err) begin
      obs_mem[obs_wr % 256] <= {32'(cyc + 1), rx_valid, rx_frame_err, rx_data};
      obs_wr <= obs_wr + 1;
    end
  end

  // driver: one 8N1 frame starting at the current negedge
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    exp_q.push_back({32'(cyc + 1 + FRAME_LAT), ~stop_bit, b});
    rx = 1'b0;
    repeat (CPB) @(negedge hwclk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge hwclk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge hwclk);
  endtask

  task automatic wait_obs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 * CPB; i++) begin
      if (obs_wr != obs_rd) begin
        ok = 1'b1;
        break;
      end
      @(negedge hwclk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge hwclk);
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b expected 0", rx_frame_err); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    n_cmp++; if (rx_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected IDLE", rx_state); end
    rst = 1'b0;
    repeat (4) @(negedge hwclk);
  endtask

  task automatic test_single();
    bit ok;
    logic [W-1:0] e;
    logic [41:0] o;
    send_byte(8'h55, 1'b1);
    wait_obs(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL single_timeout: got no strobe expected one frame"); end
    else begin
      e = exp_q.pop_front(); o = obs_mem[obs_rd % 256]; obs_rd++;
      n_cmp++; if (o[7:0] !== e[7:0]) begin n_err++; $display("FAIL single_data: got %h expected %h", o[7:0], e[7:0]); end
      n_cmp++; if (o[9:8] !== {~e[8], e[8]}) begin n_err++; $display("FAIL single_flags: got v/fe=%b expected %b", o[9:8], {~e[8], e[8]}); end
      n_cmp++; if (o[41:10] !== e[40:9]) begin n_err++; $display("FAIL single_edge: got %0d expected %0d", o[41:10], e[40:9]); end
    end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after: got %b expected 0", rx_busy); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [W-1:0] e;
    logic [41:0] o;
    logic [31:0] edges [2];
    send_byte(8'hA3, 1'b1);
    send_byte(8'h0F, 1'b1);
    for (int k = 0; k < 2; k++) begin
      wait_obs(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL b2b_timeout: frame %0d got no strobe", k); edges[k] = '0; end
      else begin
        e = exp_q.pop_front(); o = obs_mem[obs_rd % 256]; obs_rd++;
        edges[k] = o[41:10];
        n_cmp++; if (o[7:0] !== e[7:0]) begin n_err++; $display("FAIL b2b_data: frame %0d got %h expected %h", k, o[7:0], e[7:0]); end
        n_cmp++; if (o[9:8] !== {~e[8], e[8]}) begin n_err++; $display("FAIL b2b_flags: frame %0d got %b expected %b", k, o[9:8], {~e[8], e[8]}); end
        n_cmp++; if (o[41:10] !== e[40:9]) begin n_err++; $display("FAIL b2b_edge: frame %0d got %0d expected %0d", k, o[41:10], e[40:9]); end
      end
    end
    n_cmp++;
    if (edges[1] - edges[0] !== 32'd160) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 160", edges[1] - edges[0]); end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (5) @(negedge hwclk);
    rx = 1'b1;
    n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL glitch_start_seen: got busy=%b expected 1", rx_busy); end
    repeat (8) @(negedge hwclk);
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b expected 0", rx_busy); end
    repeat (2 * CPB) @(negedge hwclk);
    n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL glitch_strobe: got %0d strobes expected 0", obs_wr - obs_rd); end
    n_cmp++; if (rx_data !== 8'h0F) begin n_err++; $display("FAIL glitch_data: got %h expected 0f", rx_data); end
  endtask

  task automatic test_frame_err();
    bit ok;
    logic [W-1:0] e;
    logic [41:0] o;
    send_byte(8'hC6, 1'b0);
    repeat (100) @(negedge hwclk);
    n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL ferr_break_busy: got %b expected 1", rx_busy); end
    n_cmp++; if (obs_wr - obs_rd !== 1) begin n_err++; $display("FAIL ferr_strobe_count: got %0d expected 1", obs_wr - obs_rd); end
    rx = 1'b1;
    repeat (2 * CPB) @(negedge hwclk);
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL ferr_release_busy: got %b expected 0", rx_busy); end
    send_byte(8'h3C, 1'b1);
    for (int k = 0; k < 2; k++) begin
      wait_obs(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL ferr_timeout: frame %0d got no strobe", k); end
      else begin
        e = exp_q.pop_front(); o = obs_mem[obs_rd % 256]; obs_rd++;
        n_cmp++; if (o[7:0] !== e[7:0]) begin n_err++; $display("FAIL ferr_data: frame %0d got %h expected %h", k, o[7:0], e[7:0]); end
        n_cmp++; if (o[9:8] !== {~e[8], e[8]}) begin n_err++; $display("FAIL ferr_flags: frame %0d got %b expected %b", k, o[9:8], {~e[8], e[8]}); end
        n_cmp++; if (o[41:10] !== e[40:9]) begin n_err++; $display("FAIL ferr_edge: frame %0d got %0d expected %0d", k, o[41:10], e[40:9]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    rx = 1'b0;
    repeat (CPB) @(negedge hwclk);
    rx = 1'b1;
    repeat (70) @(negedge hwclk);
    n_cmp++; if (rx_state !== DATA) begin n_err++; $display("FAIL rmf_in_data: got state %0d expected DATA", rx_state); end
    rst = 1'b1;
    @(negedge hwclk);
    rst = 1'b0;
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rmf_data: got %h expected 00", rx_data); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL rmf_busy: got %b expected 0", rx_busy); end
    repeat (12 * CPB) @(negedge hwclk);
    n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL rmf_strobe: got %0d strobes expected 0", obs_wr - obs_rd); end
  endtask

  task automatic test_random();
    bit ok;
    logic [W-1:0] e;
    logic [41:0] o;
    for (int k = 0; k < 4; k++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      rx = 1'b1;
      repeat ($urandom_range(0, 20)) @(negedge hwclk);
    end
    for (int k = 0; k < 4; k++) begin
      wait_obs(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL rand_timeout: frame %0d got no strobe", k); end
      else begin
        e = exp_q.pop_front(); o = obs_mem[obs_rd % 256]; obs_rd++;
        n_cmp++; if (o[7:0] !== e[7:0]) begin n_err++; $display("FAIL rand_data: frame %0d got %h expected %h", k, o[7:0], e[7:0]); end
        n_cmp++; if (o[9:8] !== {~e[8], e[8]}) begin n_err++; $display("FAIL rand_flags: frame %0d got %b expected %b", k, o[9:8], {~e[8], e[8]}); end
        n_cmp++; if (o[41:10] !== e[40:9]) begin n_err++; $display("FAIL rand_edge: frame %0d got %0d expected %0d", k, o[41:10], e[40:9]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_random();
    repeat (4 * CPB) @(negedge hwclk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL final_expected_left: got %0d expected 0", exp_q.size()); end
    n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL final_extra_strobes: got %0d expected 0", obs_wr - obs_rd); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
